instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory's byte address.
- Captures the 32-bit little-endian word that the memory returns combinationally in the same cycle.
- Buffers fetched {PC, instruction} pairs in a small FIFO and hands them to decode over a valid/ready handshake; accepts redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, minimum 2.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- o_Addr  output  32  byte address to the instruction memory; always equals PC.
- i_Instruction  input  32  word returned by the instruction memory for o_Addr, same cycle.
- i_Redirect  input  1  flush the buffer and load a new PC (branch/jump/trap).
- i_Redirect_Addr  input  32  target PC, sampled when i_Redirect=1.
- o_Valid  output  1  FIFO head holds a valid instruction.
- i_Ready  input  1  decode accepts the head this cycle.
- o_Instruction  output  32  instruction at the FIFO head.
- o_PC  output  32  PC of the instruction at the FIFO head.
- o_Misaligned  output  1  redirect target had addr[1:0] != 0; fetch is halted.

Behaviour:
- Reset (i_rst=1 at an edge, any state, including mid-flight):
  - PC=RESET_PC, FIFO emptied, state=RUN.
  - o_Valid=0, o_Misaligned=0.
  - o_Instruction and o_PC read 0 while the FIFO is empty.
- States:
  - RUN: fetching.
  - HALT: misaligned target; no fetching.
- Fetch (RUN, no redirect):
  - push = !full || (o_Valid && i_Ready).
  - On push, write {PC, i_Instruction} at the FIFO tail and set PC <= PC+4.
  - Without push, PC holds and o_Addr is stable.
- Pop: o_Valid && i_Ready removes the head at the edge. Push and pop in the same cycle with the FIFO full is legal; occupancy stays unchanged.
- Latency: the first edge after reset deassertion pushes RESET_PC. o_Valid=1 in the following cycle with o_PC=RESET_PC. Sustained throughput is 1 instruction/cycle while i_Ready=1.
- Redirect (priority over push and pop; ignored while i_rst=1):
  - The FIFO is flushed.
  - The same-cycle fetch is discarded.
  - PC <= i_Redirect_Addr.
  - o_Valid=0 in the cycle after the redirect. The target instruction is presented one cycle later.
- Misaligned redirect (i_Redirect_Addr[1:0] != 0):
  - Next state HALT; PC loads the target unchanged.
  - o_Misaligned=1 from the next cycle.
  - No pushes; o_Valid stays 0.
- Leaving HALT: only an aligned redirect (returns to RUN, clears o_Misaligned) or reset. A misaligned redirect in HALT stays in HALT with PC updated.
- Wrap-around:
  - PC arithmetic is modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - Full/empty are tracked with an extra pointer bit or a count.
- Decode holding i_Ready=0: the FIFO fills to FIFO_DEPTH, then fetch stalls. The head stays stable: o_Instruction and o_PC do not change while o_Valid=1 and i_Ready=0.

Decomposition:
- Shared package rv_fetch_pkg:
  - INSTR_WIDTH=32, XLEN=32.
  - INSTR_BYTES=4.
  - NOP constant 32'h0000_0013.
  - Fetch state enum {RUN, HALT}.
- One sub-module: fetch_fifo, a parameterised synchronous FIFO with push/pop/flush/full/empty and a 64-bit {PC, instr} payload. The PC logic and FSM stay in the top.

Test Plan:
- Reset, then i_Ready=1 with the memory preloaded with words 0x00000013, 0x00100093, 0x00200113: o_PC sequence 0x0, 0x4, 0x8 on consecutive cycles, each o_Instruction equal to the little-endian byte composition.
- i_Ready=0 for 5 cycles: o_Valid=1, o_PC=0x0 held, o_Addr frozen at 0x8 (FIFO_DEPTH=2). Then i_Ready=1: 0x0, 0x4, 0x8 delivered with no loss or duplication.
- Redirect to 0x40 while the FIFO is full and i_Ready=1: o_Valid=0 the next cycle, then o_PC=0x40. Stale 0x4/0x8 are never presented.
- Redirect to 0x42: o_Misaligned=1 and o_Valid=0 for 10 cycles. A redirect to 0x80 then gives o_Misaligned=0 and o_PC=0x80.
- RESET_PC=32'hFFFF_FFF8: o_PC sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert i_rst mid-stream with the FIFO full and i_Redirect=1 in the same cycle: next cycle o_Valid=0, o_Misaligned=0, o_Addr=RESET_PC.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   XLEN / INSTR_WIDTH : address and instruction widths
//   INSTR_BYTES        : PC increment per sequential fetch
//   NOP                : canonical RV32 no-op (addi x0, x0, 0)
//   fetch_state_e      : fetch FSM states
//   fetch_entry_t      : {PC, instruction} payload held in the fetch buffer
package rv_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [XLEN-1:0]        INSTR_BYTES = 32'd4;
    localparam logic [INSTR_WIDTH-1:0] NOP         = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {PC, instruction} entries.
//   i_clk, i_rst   : clock, synchronous active-high reset (empties the FIFO)
//   i_flush        : drop all entries (lower priority than reset)
//   i_push/i_wdata : write an entry at the tail
//   i_pop          : remove the head entry
//   o_rdata        : head entry, all zeros while empty
//   o_full/o_empty : occupancy flags
// Push while full is only legal together with a pop in the same cycle.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_wdata,
    input  logic         i_pop,
    output fetch_entry_t o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra bit so full and empty are distinguishable
    // when the index bits match.
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];

    assign o_empty = (wr_q == rd_q);
    assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign o_rdata = o_empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (i_flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_q[AW-1:0]] = i_wdata;
                wr_d = wr_q + PTR_ONE;
            end
            if (i_pop) begin
                rd_d = rd_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address, buffers
// fetched {PC, instruction} pairs and hands them to decode.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   o_Addr / i_Instruction  : memory address (== PC) and same-cycle read data
//   i_Redirect(_Addr)       : flush the buffer and load a new PC
//   o_Valid / i_Ready       : handshake toward decode
//   o_Instruction / o_PC    : head-of-buffer entry (zero while empty)
//   o_Misaligned            : last redirect target was not word aligned;
//                             fetch stays halted until an aligned redirect
module instruction_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_Addr,
    input  logic [31:0] i_Instruction,
    input  logic        i_Redirect,
    input  logic [31:0] i_Redirect_Addr,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [31:0] o_Instruction,
    output logic [31:0] o_PC,
    output logic        o_Misaligned
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    fetch_entry_t wr_entry, head;

    assign o_Addr        = pc_q;
    assign o_Valid       = !fifo_empty;
    assign o_Instruction = head.instr;
    assign o_PC          = head.pc;
    assign o_Misaligned  = (state_q == HALT);
    assign wr_entry      = '{pc: pc_q, instr: i_Instruction};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fifo_push = 1'b0;
        // A redirect flushes the buffer, so the head it would have popped
        // and the word fetched this cycle are both discarded.
        fifo_pop  = o_Valid && i_Ready && !i_Redirect;
        if (i_Redirect) begin
            pc_d    = i_Redirect_Addr;
            state_d = (i_Redirect_Addr[1:0] != 2'b00) ? HALT : RUN;
        end else if (state_q == RUN) begin
            // A slot frees up this edge if decode takes the head.
            fifo_push = !fifo_full || fifo_pop;
            if (fifo_push) begin
                pc_d = pc_q + INSTR_BYTES;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_Redirect),
        .i_push  (fifo_push),
        .i_wdata (wr_entry),
        .i_pop   (fifo_pop),
        .o_rdata (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

endmodule
